mem_port_bridge: RTL and testbench

Downstream of the memory management unit: terminates its physical-side MemReq/MemResp port onto a fixed-latency, single-port, 512-bit-wide on-chip memory. Every accepted request, read or write, returns exactly one in-order MemResp, which the MMU's history queues require. A credit counter bounds outstanding requests so the response FIFO can never overflow. Out-of-range addresses are counted and answered with a benign response.

---
 rtl/mem_port_bridge_pkg.sv | 26 ++
 rtl/mem_port_bridge_fifo.sv | 43 ++++
 rtl/mem_port_bridge.sv | 124 ++++++++++++
 tb/tb_mem_port_bridge.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_bridge_pkg.sv
// Shared request/response payloads for the MMU physical-side memory port.
// Also carries the line geometry software needs to convert byte addresses to line indices.
package mem_port_bridge_pkg;

  localparam int unsigned LINE_BITS         = 512;
  localparam int unsigned ADDR_BITS         = 32;
  localparam int unsigned BRIDGE_LINE_BYTES = LINE_BITS / 8;

  typedef struct packed {
    logic                 valid;
    logic                 isWrite;
    logic [LINE_BITS-1:0] data;
    logic [ADDR_BITS-1:0] addr;
  } MemReq;

  typedef struct packed {
    logic                 valid;
    logic [LINE_BITS-1:0] data;
  } MemResp;

  // True when any address bit above the line index is set.
  function automatic logic is_oob(input logic [ADDR_BITS-1:0] addr, input int unsigned index_bits);
    return (addr >> index_bits) != '0;
  endfunction

endpackage

// File: rtl/mem_port_bridge_fifo.sv
// Power-of-two circular FIFO with a combinational head; push while full or pop while empty is ignored.
module mem_port_bridge_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]   storage [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr;
  logic [LOG_DEPTH:0] rd_ptr;
  logic               full;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]) &&
                 (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) storage[wr_ptr[LOG_DEPTH-1:0]] <= push_data;
  end

  assign pop_data = storage[rd_ptr[LOG_DEPTH-1:0]];

endmodule

// File: rtl/mem_port_bridge.sv
// Terminates the MMU MemReq/MemResp port onto a fixed-latency single-port line memory,
// returning exactly one in-order response per accepted request under credit flow control.
module mem_port_bridge
  import mem_port_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned LOG_RESP_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  MemReq                 req,
  output logic                  req_grant,
  output MemResp                resp,
  input  logic                  resp_grant,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_BITS-1:0]  mem_wdata,
  input  logic [LINE_BITS-1:0]  mem_rdata,
  output logic                  busy,
  output logic [15:0]           oob_count
);

  localparam int unsigned         CREDIT_W   = LOG_RESP_DEPTH + 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(1 << LOG_RESP_DEPTH);
  localparam logic [15:0]         OOB_MAX    = 16'hFFFF;

  logic [CREDIT_W-1:0]     credit_cnt;
  logic                    req_oob;
  logic                    accept;
  logic                    pop;
  logic                    fifo_empty;
  MemResp                  push_entry;
  MemResp                  head;
  logic [READ_LATENCY-1:0] trk_valid;
  logic [READ_LATENCY-1:0] trk_write;
  logic [READ_LATENCY-1:0] trk_oob;

  // Grant depends only on registered credits, so a same-cycle pop cannot reopen it.
  assign req_oob   = is_oob(req.addr, ADDR_WIDTH);
  assign accept    = req.valid && (credit_cnt < CREDIT_MAX) && !rst;
  assign req_grant = accept;
  assign pop       = !fifo_empty && resp_grant;
  assign busy      = (credit_cnt != '0);

  // Memory strobe; out-of-range accesses never touch the array.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept && !req_oob) begin
      mem_en    = 1'b1;
      mem_we    = req.isWrite;
      mem_addr  = req.addr[ADDR_WIDTH-1:0];
      mem_wdata = req.data;
    end
  end

  // Tracker runs in lockstep with the memory read pipeline and never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_valid <= '0;
      trk_write <= '0;
      trk_oob   <= '0;
    end else begin
      trk_valid[0] <= accept;
      trk_write[0] <= req.isWrite;
      trk_oob[0]   <= req_oob;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_write[i] <= trk_write[i-1];
        trk_oob[i]   <= trk_oob[i-1];
      end
    end
  end

  // Writes and out-of-range accesses complete with zero data.
  always_comb begin
    push_entry       = '0;
    push_entry.valid = 1'b1;
    if (!trk_write[READ_LATENCY-1] && !trk_oob[READ_LATENCY-1]) begin
      push_entry.data = mem_rdata;
    end
  end

  mem_port_bridge_fifo #(
    .WIDTH     ($bits(MemResp)),
    .LOG_DEPTH (LOG_RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (trk_valid[READ_LATENCY-1]),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  assign resp.valid = !fifo_empty && head.valid;
  assign resp.data  = head.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credit_cnt <= credit_cnt + 1'b1;
        2'b01:   credit_cnt <= credit_cnt - 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_count <= '0;
    end else if (accept && req_oob && (oob_count != OOB_MAX)) begin
      oob_count <= oob_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed bench for mem_port_bridge with a write-first, fixed-latency line memory model.
module tb_mem_port_bridge;
  import mem_port_bridge_pkg::*;

  localparam int unsigned AW   = 10;
  localparam int unsigned LAT  = 2;
  localparam int unsigned LOGD = 3;

  logic           clk = 1'b0;
  logic           rst;
  MemReq          req;
  logic           req_grant;
  MemResp         resp;
  logic           resp_grant;
  logic           mem_en;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [511:0]   mem_wdata;
  logic [511:0]   mem_rdata;
  logic           busy;
  logic [15:0]    oob_count;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;
  int nresp = 0;
  logic [511:0] exp_q [$];
  logic [511:0] shadow [1<<AW];

  always #5 clk = ~clk;

  mem_port_bridge #(
    .ADDR_WIDTH     (AW),
    .READ_LATENCY   (LAT),
    .LOG_RESP_DEPTH (LOGD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_grant  (req_grant),
    .resp       (resp),
    .resp_grant (resp_grant),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .oob_count  (oob_count)
  );

  function automatic logic [511:0] pat(input int i);
    if (i == 5) return {64{8'hA5}};
    return {16{32'(i) ^ 32'hC0DE_0000}};
  endfunction

  // Write-first memory with LAT-cycle read pipeline; contents reload while rst is high.
  logic [511:0] mem [1<<AW];
  logic [511:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_en) rd_pipe[0] <= mem_we ? mem_wdata : mem[mem_addr];
    for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_grant"}, 512'(req_grant), 512'(0));
    chk({tag, "_resp_valid"}, 512'(resp.valid), 512'(0));
    chk({tag, "_mem_en"}, 512'(mem_en), 512'(0));
    chk({tag, "_mem_we"}, 512'(mem_we), 512'(0));
    chk({tag, "_mem_addr"}, 512'(mem_addr), 512'(0));
    chk({tag, "_mem_wdata"}, mem_wdata, 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_oob_count"}, 512'(oob_count), 512'(0));
  endtask

  // In-order response scoreboard, sampled mid-cycle before the popping edge.
  always @(negedge clk) begin
    if (mon_on && resp.valid && resp_grant) begin
      chk("t5_resp_expected", 512'(exp_q.size() != 0), 512'(1));
      if (exp_q.size() != 0) chk("t5_resp_data", resp.data, exp_q.pop_front());
      nresp++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int n;
    int cyc;
    logic [511:0] d;
    logic [AW-1:0] a;

    rst = 1'b1;
    req = '0;
    resp_grant = 1'b0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = pat(i);

    // Reset: grant held low even with a valid request.
    req.valid = 1'b1;
    req.addr  = 32'd5;
    #2;
    chk_reset_outputs("t0");
    repeat (3) @(posedge clk);
    #1;
    req = '0;
    rst = 1'b0;

    // Single read of preloaded line 5.
    step();
    req.valid = 1'b1; req.isWrite = 1'b0; req.addr = 32'd5;
    #1;
    chk("t1_grant", 512'(req_grant), 512'(1));
    chk("t1_mem_en", 512'(mem_en), 512'(1));
    chk("t1_mem_addr", 512'(mem_addr), 512'(5));
    step(); req = '0; #1;
    chk("t1_busy_t1", 512'(busy), 512'(1));
    chk("t1_resp_t1", 512'(resp.valid), 512'(0));
    step(); #1;
    chk("t1_resp_t2", 512'(resp.valid), 512'(0));
    step(); #1;
    chk("t1_resp_t3", 512'(resp.valid), 512'(1));
    chk("t1_data", resp.data, {64{8'hA5}});
    resp_grant = 1'b1;
    step(); resp_grant = 1'b0; #1;
    chk("t1_resp_after", 512'(resp.valid), 512'(0));
    chk("t1_busy_after", 512'(busy), 512'(0));

    // Write then read the same line in consecutive cycles.
    step();
    req.valid = 1'b1; req.isWrite = 1'b1; req.addr = 32'd7; req.data = 512'h1234;
    #1;
    chk("t2_wr_grant", 512'(req_grant), 512'(1));
    chk("t2_wr_we", 512'(mem_we), 512'(1));
    step();
    req.isWrite = 1'b0; req.data = '0;
    #1;
    chk("t2_rd_grant", 512'(req_grant), 512'(1));
    chk("t2_rd_we", 512'(mem_we), 512'(0));
    step(); req = '0; #1;
    chk("t2_resp_early", 512'(resp.valid), 512'(0));
    step(); #1;
    chk("t2_resp0_valid", 512'(resp.valid), 512'(1));
    chk("t2_resp0_data", resp.data, 512'(0));
    resp_grant = 1'b1;
    step(); #1;
    chk("t2_resp1_valid", 512'(resp.valid), 512'(1));
    chk("t2_resp1_data", resp.data, 512'h1234);
    step(); resp_grant = 1'b0; #1;
    chk("t2_resp_drained", 512'(resp.valid), 512'(0));
    chk("t2_busy", 512'(busy), 512'(0));

    // Credit limit: 12 reads offered with no pops.
    step();
    grants = 0;
    req.valid = 1'b1; req.isWrite = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req.addr = 32'(i);
      #1;
      if (req_grant) grants++;
      step();
    end
    chk("t3_grants", 512'(grants), 512'(8));
    #1;
    chk("t3_full_grant", 512'(req_grant), 512'(0));
    resp_grant = 1'b1;
    #1;
    chk("t3_pop_same_cycle", 512'(req_grant), 512'(0));
    step(); resp_grant = 1'b0; #1;
    chk("t3_reopen", 512'(req_grant), 512'(1));
    step(); #1;
    chk("t3_closed_again", 512'(req_grant), 512'(0));
    req = '0;
    resp_grant = 1'b1;
    repeat (12) step();
    resp_grant = 1'b0;
    #1;
    chk("t3_busy", 512'(busy), 512'(0));
    chk("t3_resp_empty", 512'(resp.valid), 512'(0));

    // Out-of-range read, then saturation of the counter.
    step();
    req.valid = 1'b1; req.isWrite = 1'b0; req.addr = 32'h0001_0000;
    resp_grant = 1'b1;
    #1;
    chk("t4_grant", 512'(req_grant), 512'(1));
    chk("t4_mem_en", 512'(mem_en), 512'(0));
    step(); req = '0; #1;
    chk("t4_oob_count", 512'(oob_count), 512'(1));
    step(); step(); #1;
    chk("t4_resp_valid", 512'(resp.valid), 512'(1));
    chk("t4_resp_data", resp.data, 512'(0));
    step(); #1;
    chk("t4_resp_popped", 512'(resp.valid), 512'(0));
    req.valid = 1'b1; req.isWrite = 1'b1; req.addr = 32'hFFFF_0003; req.data = '1;
    n = 0; cyc = 0;
    #1;
    while (n < 70000 && cyc < 80000) begin
      if (req_grant) n++;
      cyc++;
      step(); #1;
    end
    req = '0;
    chk("t4_sat_grants", 512'(n), 512'(70000));
    repeat (6) step();
    #1;
    chk("t4_saturated", 512'(oob_count), 512'(16'hFFFF));
    chk("t4_busy", 512'(busy), 512'(0));

    // Streaming alternating reads and writes against the scoreboard.
    mon_on = 1'b1;
    nresp = 0;
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      a = AW'(100 + (i % 16));
      req.valid = 1'b1; req.isWrite = i[0]; req.addr = 32'(a); req.data = d;
      #1;
      chk("t5_grant", 512'(req_grant), 512'(1));
      if (i[0]) begin
        exp_q.push_back('0);
        shadow[a] = d;
      end else begin
        exp_q.push_back(shadow[a]);
      end
      step();
    end
    req = '0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    step();
    mon_on = 1'b0;
    chk("t5_resp_count", 512'(nresp), 512'(100));
    chk("t5_queue_empty", 512'(exp_q.size()), 512'(0));

    // Reset mid-stream with three requests in flight.
    resp_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req.valid = 1'b1; req.isWrite = 1'b0; req.addr = 32'(i);
      #1;
      chk("t6_grant", 512'(req_grant), 512'(1));
      step();
    end
    req.addr = 32'd3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    step();
    req = '0;
    step();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t6_no_stale_resp", 512'(resp.valid), 512'(0));
      chk("t6_busy", 512'(busy), 512'(0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
